// File: rtl/core_pkg.sv
// Shared core types: funct3 access codes, LSU states, exception causes.
// Also hosts the request-legality check used at LSU acceptance.
package core_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b10;

  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } lsu_req_t;

  // Illegal funct3 wins over misalignment.
  function automatic logic [1:0] lsu_check(
    input logic       st,
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic [1:0] c;
    c = EXC_NONE;
    case (f3)
      F3_B:    c = EXC_NONE;
      F3_H:    c = lo[0] ? EXC_MISALIGN : EXC_NONE;
      F3_W:    c = (lo != 2'b00) ? EXC_MISALIGN : EXC_NONE;
      F3_BU:   c = st ? EXC_ILLEGAL : EXC_NONE;
      F3_HU:   c = st ? EXC_ILLEGAL
                 : (lo[0] ? EXC_MISALIGN : EXC_NONE);
      default: c = EXC_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store strobes/replication and load extract/extend.
// Purely combinational; fed from the captured request fields.
module lsu_align
  import core_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [7:0]  lbyte;
  logic [15:0] lhalf;
  logic        sx;

  always_comb begin
    lbyte = rdata[{addr_lo, 3'b000} +: 8];
    lhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    sx    = ~funct3[2];
    wstrb = 4'b1111;
    wdata = store_data;
    ldata = rdata;
    case (funct3[1:0])
      2'b00: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
        ldata = {{24{lbyte[7] & sx}}, lbyte};
      end
      2'b01: begin
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
        ldata = {{16{lhalf[15] & sx}}, lhalf};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = store_data;
        ldata = rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single outstanding access, IDLE/REQ/RESP FSM.
// Faulting requests never reach memory and report one cycle later.
module lsu
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_addr
);

  lsu_state_t  state;
  lsu_state_t  state_nxt;
  lsu_req_t    req_q;
  logic        accept;
  logic        in_req;
  logic        st_req;
  logic        rsp;
  logic [31:0] ea;
  logic [1:0]  chk;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_ldata;

  assign ea        = base + offset;
  assign chk       = lsu_check(is_store, funct3, ea[1:0]);
  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign in_req    = (state == REQ);
  assign st_req    = in_req && req_q.is_store;
  assign rsp       = (state == RESP) && mem_rvalid;

  lsu_align u_align (
    .funct3     (req_q.funct3),
    .addr_lo    (req_q.addr[1:0]),
    .store_data (req_q.wdata),
    .rdata      (mem_rdata),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .ldata      (al_ldata)
  );

  assign mem_req   = in_req;
  assign mem_we    = st_req;
  assign mem_addr  = in_req ? {req_q.addr[31:2], 2'b00} : '0;
  assign mem_wstrb = st_req ? al_wstrb : 4'b0000;
  assign mem_wdata = st_req ? al_wdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept && chk == EXC_NONE) state_nxt = REQ;
      REQ:     if (mem_gnt) state_nxt = req_q.is_store ? IDLE : RESP;
      RESP:    if (mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q     <= '0;
      exc_valid <= 1'b0;
      exc_cause <= EXC_NONE;
      exc_addr  <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else begin
      exc_valid <= accept && (chk != EXC_NONE);
      wb_valid  <= rsp;
      if (accept) begin
        req_q.is_store <= is_store;
        req_q.funct3   <= funct3;
        req_q.addr     <= ea;
        req_q.wdata    <= store_data;
        req_q.rd       <= rd_in;
      end
      if (accept && chk != EXC_NONE) begin
        exc_cause <= chk;
        exc_addr  <= ea;
      end
      if (rsp) begin
        wb_rd   <= req_q.rd;
        wb_data <= al_ldata;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized
// traffic against a byte-addressed memory model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] base = '0;
  logic [31:0] offset = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  rd_in = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem_b [logic [31:0]];

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .funct3(funct3),
    .base(base), .offset(offset),
    .store_data(store_data), .rd_in(rd_in),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_addr(exc_addr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] read_word(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] ba;
    for (int i = 0; i < 4; i++) begin
      ba = a + i;
      w[8*i +: 8] = mem_b.exists(ba) ? mem_b[ba] : (ba[7:0] ^ 8'h5A);
    end
    return w;
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem_b[a + i] = w[8*i +: 8];
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_timeout: req_ready=%b want 1", req_ready);
    end
  endtask

  // Full transaction with inline checks against the reference rules.
  task automatic do_txn(
    input bit          st,
    input logic [2:0]  f3,
    input logic [31:0] b,
    input logic [31:0] off,
    input logic [31:0] sd,
    input logic [4:0]  rd,
    input int          gd,
    input int          rvd
  );
    logic [31:0] ea, rw, exp_wd, exp_ld, msk;
    logic [3:0]  exp_st;
    logic [1:0]  exp_exc;
    int          n, lo;
    ea = b + off;
    lo = int'(ea % 4);
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    exp_exc = 2'b00;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (st && f3[2]))
      exp_exc = 2'b10;
    else if (lo % n != 0)
      exp_exc = 2'b01;
    exp_st = 4'b0000;
    exp_wd = '0;
    if (exp_exc == 2'b00)
      for (int i = 0; i < n; i++) exp_st[lo + i] = 1'b1;
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = sd[8*(i % n) +: 8];
    rw = read_word(ea & ~32'd3);
    exp_ld = rw >> (8 * lo);
    if (n < 4) begin
      msk = (32'd1 << (8 * n)) - 32'd1;
      exp_ld = exp_ld & msk;
      if (!f3[2] && exp_ld[8*n-1]) exp_ld = exp_ld | ~msk;
    end

    wait_ready();
    req_valid = 1'b1; is_store = st; funct3 = f3;
    base = b; offset = off; store_data = sd; rd_in = rd;
    step();
    req_valid = 1'b0;

    if (exp_exc != 2'b00) begin
      vectors += 4;
      if (exc_valid !== 1'b1) begin miscompares++;
        $display("FAIL exc_valid: got %b want 1", exc_valid); end
      if (exc_cause !== exp_exc) begin miscompares++;
        $display("FAIL exc_cause: got %b want %b", exc_cause, exp_exc); end
      if (exc_addr !== ea) begin miscompares++;
        $display("FAIL exc_addr: got %h want %h", exc_addr, ea); end
      if (mem_req !== 1'b0) begin miscompares++;
        $display("FAIL exc_no_mem: mem_req=%b want 0", mem_req); end
      step();
      vectors += 2;
      if (exc_valid !== 1'b0) begin miscompares++;
        $display("FAIL exc_pulse: got %b want 0", exc_valid); end
      if (mem_req !== 1'b0) begin miscompares++;
        $display("FAIL exc_no_mem2: mem_req=%b want 0", mem_req); end
      return;
    end

    for (int k = 0; k <= gd; k++) begin
      vectors += 4;
      if (mem_req !== 1'b1) begin miscompares++;
        $display("FAIL mem_req k=%0d: got %b want 1", k, mem_req); end
      if (mem_addr !== (ea & ~32'd3)) begin miscompares++;
        $display("FAIL mem_addr: got %h want %h", mem_addr, ea & ~32'd3); end
      if (mem_we !== st) begin miscompares++;
        $display("FAIL mem_we: got %b want %b", mem_we, st); end
      if (req_ready !== 1'b0) begin miscompares++;
        $display("FAIL busy_ready: got %b want 0", req_ready); end
      if (st) begin
        vectors += 2;
        if (mem_wstrb !== exp_st) begin miscompares++;
          $display("FAIL mem_wstrb: got %b want %b", mem_wstrb, exp_st); end
        if (mem_wdata !== exp_wd) begin miscompares++;
          $display("FAIL mem_wdata: got %h want %h", mem_wdata, exp_wd); end
      end
      if (k == gd) mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
    end

    if (st) begin
      vectors += 3;
      if (mem_req !== 1'b0) begin miscompares++;
        $display("FAIL st_done_req: got %b want 0", mem_req); end
      if (req_ready !== 1'b1) begin miscompares++;
        $display("FAIL st_ready: got %b want 1", req_ready); end
      if (wb_valid !== 1'b0) begin miscompares++;
        $display("FAIL st_no_wb: got %b want 0", wb_valid); end
      for (int i = 0; i < 4; i++)
        if (exp_st[i]) mem_b[(ea & ~32'd3) + i] = exp_wd[8*i +: 8];
      return;
    end

    for (int k = 0; k < rvd; k++) begin
      vectors += 2;
      if (wb_valid !== 1'b0) begin miscompares++;
        $display("FAIL early_wb: got %b want 0", wb_valid); end
      if (mem_req !== 1'b0) begin miscompares++;
        $display("FAIL resp_req: got %b want 0", mem_req); end
      step();
    end
    mem_rvalid = 1'b1;
    mem_rdata = rw;
    step();
    mem_rvalid = 1'b0;
    mem_rdata = $urandom;
    vectors += 3;
    if (wb_valid !== 1'b1) begin miscompares++;
      $display("FAIL wb_valid: got %b want 1", wb_valid); end
    if (wb_rd !== rd) begin miscompares++;
      $display("FAIL wb_rd: got %0d want %0d", wb_rd, rd); end
    if (wb_data !== exp_ld) begin miscompares++;
      $display("FAIL wb_data: got %h want %h", wb_data, exp_ld); end
    step();
    vectors++;
    if (wb_valid !== 1'b0) begin miscompares++;
      $display("FAIL wb_pulse: got %b want 0", wb_valid); end
  endtask

  task automatic test_reset();
    step();
    vectors += 6;
    if (req_ready !== 1'b1) begin miscompares++;
      $display("FAIL rst_ready: got %b want 1", req_ready); end
    if (mem_req !== 1'b0 || mem_we !== 1'b0) begin miscompares++;
      $display("FAIL rst_mem: req=%b we=%b want 0 0", mem_req, mem_we); end
    if (mem_wstrb !== 4'b0000) begin miscompares++;
      $display("FAIL rst_wstrb: got %b want 0000", mem_wstrb); end
    if (mem_addr !== '0 || mem_wdata !== '0) begin miscompares++;
      $display("FAIL rst_data: addr=%h wdata=%h want 0", mem_addr, mem_wdata); end
    if (wb_valid !== 1'b0 || exc_valid !== 1'b0) begin miscompares++;
      $display("FAIL rst_pulses: wb=%b exc=%b want 0 0", wb_valid, exc_valid); end
    if (wb_data !== '0 || wb_rd !== '0 || exc_addr !== '0) begin miscompares++;
      $display("FAIL rst_regs: wb_data=%h wb_rd=%0d exc_addr=%h want 0",
               wb_data, wb_rd, exc_addr); end
    rst = 1'b0;
    step();
    mem_gnt = 1'b1;
    mem_rvalid = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    vectors += 2;
    if (mem_req !== 1'b0) begin miscompares++;
      $display("FAIL idle_gnt: mem_req=%b want 0", mem_req); end
    if (wb_valid !== 1'b0) begin miscompares++;
      $display("FAIL idle_rvalid: wb_valid=%b want 0", wb_valid); end
  endtask

  task automatic test_lb();
    set_word(32'h1000, 32'h80FF_FF00);
    do_txn(1'b0, 3'b000, 32'h1000, 32'd3, 32'h0, 5'd7, 0, 0);
  endtask

  task automatic test_sh();
    do_txn(1'b1, 3'b001, 32'h2000, 32'd2, 32'h0000_ABCD, 5'd0, 0, 0);
    do_txn(1'b1, 3'b000, 32'h2000, 32'd1, 32'h1234_5678, 5'd0, 1, 0);
    do_txn(1'b1, 3'b010, 32'h2000, 32'd4, 32'hDEAD_BEEF, 5'd0, 0, 0);
  endtask

  task automatic test_exceptions();
    do_txn(1'b0, 3'b010, 32'h1000, 32'd2, 32'h0, 5'd3, 0, 0);
    do_txn(1'b0, 3'b011, 32'h1000, 32'd0, 32'h0, 5'd3, 0, 0);
    do_txn(1'b1, 3'b100, 32'h1000, 32'd0, 32'h0, 5'd3, 0, 0);
    do_txn(1'b0, 3'b110, 32'h1001, 32'd0, 32'h0, 5'd3, 0, 0);
    do_txn(1'b0, 3'b101, 32'h1003, 32'd0, 32'h0, 5'd3, 0, 0);
  endtask

  task automatic test_lhu_delay();
    set_word(32'h3000, 32'hF00D_1234);
    do_txn(1'b0, 3'b101, 32'h3000, 32'd2, 32'h0, 5'd12, 4, 2);
    do_txn(1'b0, 3'b000, 32'hFFFF_FFFC, 32'd8, 32'h0, 5'd0, 0, 0);
  endtask

  task automatic test_reset_resp();
    wait_ready();
    req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010;
    base = 32'h5000; offset = 32'd0; rd_in = 5'd4;
    step();
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    vectors++;
    if (req_ready !== 1'b0) begin miscompares++;
      $display("FAIL resp_busy: req_ready=%b want 0", req_ready); end
    rst = 1'b1;
    #1;
    vectors += 2;
    if (req_ready !== 1'b1) begin miscompares++;
      $display("FAIL async_rst_ready: got %b want 1", req_ready); end
    if (mem_req !== 1'b0 || mem_addr !== '0) begin miscompares++;
      $display("FAIL async_rst_mem: req=%b addr=%h want 0", mem_req, mem_addr); end
    step();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    step();
    mem_rvalid = 1'b0;
    vectors += 2;
    if (wb_valid !== 1'b0) begin miscompares++;
      $display("FAIL late_rvalid: wb_valid=%b want 0", wb_valid); end
    if (req_ready !== 1'b1) begin miscompares++;
      $display("FAIL post_rst_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_back_to_back();
    set_word(32'h6000, 32'h1122_3344);
    set_word(32'h7000, 32'h99AA_BBCC);
    wait_ready();
    req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010;
    base = 32'h7000; offset = 32'd0; rd_in = 5'd8;
    step();
    funct3 = 3'b100; base = 32'h6000; offset = 32'd1; rd_in = 5'd9;
    vectors += 2;
    if (req_ready !== 1'b0) begin miscompares++;
      $display("FAIL b2b_ready_req: got %b want 0", req_ready); end
    if (mem_addr !== 32'h7000) begin miscompares++;
      $display("FAIL b2b_addr_a: got %h want 7000", mem_addr); end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    vectors += 2;
    if (req_ready !== 1'b0) begin miscompares++;
      $display("FAIL b2b_ready_resp: got %b want 0", req_ready); end
    if (mem_req !== 1'b0) begin miscompares++;
      $display("FAIL b2b_resp_req: got %b want 0", mem_req); end
    mem_rvalid = 1'b1;
    mem_rdata = read_word(32'h7000);
    step();
    mem_rvalid = 1'b0;
    vectors += 3;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd8) begin miscompares++;
      $display("FAIL b2b_wb_a: valid=%b rd=%0d want 1 8", wb_valid, wb_rd); end
    if (wb_data !== 32'h99AA_BBCC) begin miscompares++;
      $display("FAIL b2b_data_a: got %h want 99aabbcc", wb_data); end
    if (req_ready !== 1'b1) begin miscompares++;
      $display("FAIL b2b_ready_back: got %b want 1", req_ready); end
    step();
    req_valid = 1'b0;
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h6000) begin miscompares++;
      $display("FAIL b2b_addr_b: req=%b addr=%h want 1 6000", mem_req, mem_addr); end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = read_word(32'h6000);
    step();
    mem_rvalid = 1'b0;
    vectors++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd9 || wb_data !== 32'h0000_0033) begin
      miscompares++;
      $display("FAIL b2b_wb_b: valid=%b rd=%0d data=%h want 1 9 00000033",
               wb_valid, wb_rd, wb_data);
    end
  endtask

  task automatic test_random();
    logic [31:0] off;
    for (int t = 0; t < 60; t++) begin
      off = 32'($urandom_range(0, 15)) - 32'd8;
      do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'h4000 + 32'($urandom_range(0, 31)), off, $urandom,
             5'($urandom_range(0, 31)), $urandom_range(0, 2),
             $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_exceptions();
    test_lhu_delay();
    test_reset_resp();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
